// File: rtl/counter_ctrl.sv
// -----------------------------------------------------------------------------
// counter_ctrl
//
// WIDTH-bit up/down counter with a two-state run controller.
// In STOP the count advances only on a step pulse. In RUN it advances on each
// prescaler tick, and a tick occurs once every DIV clock cycles.
// clr and load override the advance paths. All outputs are registered, and every
// input pulse affects the outputs one clock later.
//
// Parameters
//   WIDTH    counter width in bits
//   DIV      prescaler period in clk cycles (2 .. 2**26)
//
// Ports
//   clk       in   1      single clock, rising edge
//   rst       in   1      synchronous, active-high reset (highest priority)
//   step      in   1      advance the count by one while in STOP
//   run_tgl   in   1      toggle STOP <-> RUN
//   dir       in   1      1 = count up, 0 = count down
//   load      in   1      copy load_val into count
//   load_val  in   WIDTH  value applied by load
//   clr       in   1      zero the count and force STOP
//   count     out  WIDTH  counter value
//   running   out  1      1 while in RUN
//   tick      out  1      one-cycle pulse on each prescaler expiry in RUN
//   wrap      out  1      one-cycle pulse together with a wrapped count value
// -----------------------------------------------------------------------------
module counter_ctrl #(
   parameter int WIDTH = 18,
   parameter int DIV   = 50000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             step,
   input  logic             run_tgl,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr,
   output logic [WIDTH-1:0] count,
   output logic             running,
   output logic             tick,
   output logic             wrap
);

   // Prescaler counts 0 .. DIV-1, so clog2(DIV) bits are always enough.
   localparam int            PW         = $clog2(DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

   typedef enum logic {
      ST_STOP = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             running_q, running_d;
   logic             tick_q, tick_d;
   logic             wrap_q, wrap_d;

   logic             expire_s;
   logic             advance_s;

   // Next count value for one advance in the given direction (modulo 2**WIDTH).
   function automatic logic [WIDTH-1:0] f_next_count(input logic [WIDTH-1:0] c,
                                                     input logic             up);
      logic [WIDTH-1:0] r;
      if (up) begin
         r = c + WIDTH'(1);
      end else begin
         r = c - WIDTH'(1);
      end
      return r;
   endfunction

   // True when advancing from c in the given direction crosses the modulo boundary.
   function automatic logic f_wraps(input logic [WIDTH-1:0] c,
                                    input logic             up);
      logic r;
      if (up) begin
         r = &c;
      end else begin
         r = ~|c;
      end
      return r;
   endfunction

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_STOP;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic. clr forces STOP and masks run_tgl. load does not affect the state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_STOP: begin
            if (run_tgl) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_STOP;
            end
         end
         ST_RUN: begin
            if (run_tgl) begin
               state_d = ST_STOP;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_STOP;
         end
      endcase
      if (clr) begin
         state_d = ST_STOP;
      end else begin
         state_d = state_d;
      end
   end

   // FSM output logic. running is registered from the next state, so it changes one cycle after run_tgl.
   always_comb begin
      running_d = 1'b0;
      case (state_d)
         ST_RUN:  running_d = 1'b1;
         ST_STOP: running_d = 1'b0;
         default: running_d = 1'b0;
      endcase
   end

   // The prescaler expires when it holds its last value while in RUN.
   // The count advances on the registered tick, one cycle after the tick becomes visible. In STOP it advances on step.
   assign expire_s  = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
   assign advance_s = (state_q == ST_RUN) ? tick_q : step;

   // Datapath next-state logic. Priority order: clr, then load, then advance.
   always_comb begin
      count_d = count_q;
      presc_d = presc_q;
      tick_d  = 1'b0;
      wrap_d  = 1'b0;
      if (clr) begin
         count_d = {WIDTH{1'b0}};
         presc_d = {PW{1'b0}};
         tick_d  = 1'b0;
         wrap_d  = 1'b0;
      end else begin
         tick_d = expire_s;
         if (load) begin
            count_d = load_val;
            wrap_d  = 1'b0;
         end else if (advance_s) begin
            count_d = f_next_count(count_q, dir);
            wrap_d  = f_wraps(count_q, dir);
         end else begin
            count_d = count_q;
            wrap_d  = 1'b0;
         end
         // The prescaler stays at zero through the STOP->RUN cycle, so the first tick comes DIV cycles after running rises.
         if (load || expire_s || (state_q == ST_STOP) || (state_d == ST_STOP)) begin
            presc_d = {PW{1'b0}};
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= {WIDTH{1'b0}};
         presc_q   <= {PW{1'b0}};
         running_q <= 1'b0;
         tick_q    <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         count_q   <= count_d;
         presc_q   <= presc_d;
         running_q <= running_d;
         tick_q    <= tick_d;
         wrap_q    <= wrap_d;
      end
   end

   assign count   = count_q;
   assign running = running_q;
   assign tick    = tick_q;
   assign wrap    = wrap_q;

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 18, counter width in bits.
REQ-002 SHALL have parameter DIV, default 50000000, prescaler period in clk cycles for auto-run ticks; legal range 2..2^26.
REQ-003 SHALL have clk  input  1  single clock; every register updates on its rising edge.
REQ-004 SHALL have rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have step  input  1  single-cycle pulse; advances count by one while in STOP.
REQ-006 SHALL have run_tgl  input  1  single-cycle pulse; toggles between STOP and RUN.
REQ-007 SHALL have dir  input  1  count direction: 1 = up, 0 = down; sampled on every cycle in which count advances.
REQ-008 SHALL have load  input  1  single-cycle pulse; copies load_val into count.
REQ-009 SHALL have load_val  input  WIDTH  value applied by load.
REQ-010 SHALL have clr  input  1  single-cycle pulse; zeroes count and forces STOP.
REQ-011 SHALL have count  output  WIDTH  registered counter value.
REQ-012 SHALL have running  output  1  registered; 1 when in RUN.
REQ-013 SHALL have tick  output  1  registered; one-cycle pulse on each prescaler expiry in RUN.
REQ-014 SHALL have wrap  output  1  registered; one-cycle pulse when count wraps.

Function
REQ-015 SHALL implement a two-state FSM: STOP (running=0) and RUN (running=1).
REQ-016 SHALL move STOP->RUN on run_tgl and RUN->STOP on run_tgl, provided clr is low.
REQ-017 SHALL keep a prescaler counter of width clog2(DIV); it is held at 0 in STOP and increments each cycle in RUN.
REQ-018 SHALL set the prescaler back to 0 and assert tick for one cycle when the prescaler reaches DIV-1 in RUN, so ticks occur every DIV cycles.
REQ-019 SHALL hold the prescaler at 0 on the STOP->RUN transition cycle, so the first tick follows DIV cycles after running becomes 1.
REQ-020 SHALL advance count by one in the cycle after an advance event: either tick in RUN, or step in STOP.
REQ-021 SHALL ignore step while in RUN.
REQ-022 SHALL apply modulo-2^WIDTH arithmetic: up from 2^WIDTH-1 gives 0, and down from 0 gives 2^WIDTH-1.
REQ-023 SHALL pulse wrap in the same cycle that the wrapped count value appears on count.
REQ-024 SHALL apply priority per cycle of clr > load > advance; the lower-priority events in that cycle are discarded.
REQ-025 On clr, SHALL set count=0, enter STOP, zero the prescaler, suppress tick and wrap, and ignore a simultaneous run_tgl.
REQ-026 On load, SHALL set count=load_val and zero the prescaler, keep the FSM state (run_tgl in the same cycle still toggles), and never assert wrap.
REQ-027 SHALL have a latency of one clk cycle from any input pulse to its effect on the outputs.
REQ-028 SHALL treat a pulse held for N cycles as N events; pulse shaping is the upstream edge detector's responsibility.

Reset
REQ-029 SHALL, with rst high at a rising clk edge, set count=0, state=STOP, prescaler=0, running=0, tick=0, wrap=0.
REQ-030 SHALL give rst priority over all other inputs, including mid-run and mid-prescale.
REQ-031 SHALL not act on any input during the cycles in which rst is high.

Verification (WIDTH=4, DIV=4)
REQ-032 Reset, then three step pulses with dir=1 -> count=3, running=0, no tick.
REQ-033 run_tgl with dir=1 from count=3 -> running=1 next cycle; ticks at cycles 4, 8, 12 after; count 4, 5, 6, each one cycle after its tick.
REQ-034 load_val=15, load, then step with dir=1 -> count 15 then 0 with wrap=1 for one cycle; then step with dir=0 -> count 15 with wrap=1.
REQ-035 In RUN, assert clr and run_tgl in the same cycle -> count=0, running=0, no further ticks over 20 cycles.
REQ-036 In RUN, load and step in the same cycle as a tick -> count=load_val, prescaler restarts, next tick DIV cycles later.
REQ-037 Assert rst mid-run at prescaler=2 with count=9 -> next cycle count=0, running=0, tick=0, wrap=0.
